level_timer: RTL and testbench

LEVEL_TIMER -- requirements
Module: level_timer

---
 rtl/game_pkg.sv | 16 +
 rtl/tick_gen.sv | 32 +++
 rtl/level_timer.sv | 127 ++++++++++++
 tb/tb_level_timer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the level timer state encoding.
// MAX_TIME must fit two BCD digits (<= 99) and LEVEL_TIME must not exceed MAX_TIME.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_TIMEOUT = 2'd3
    } timer_state_t;

    localparam int LEVEL_TIME_DEF = 60;
    localparam int BONUS_TIME_DEF = 10;
    localparam int MAX_TIME_DEF   = 99;

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while en, pulses tick on terminal count.
// Holds its count while en is low; clr forces it back to zero.
module tick_gen #(
    parameter int CLK_HZ = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);

    logic [W-1:0] r_cnt;
    logic         w_term;

    assign w_term = (r_cnt == TERM);
    assign tick   = en & ~clr & w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_term ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/level_timer.sv
// Per-level countdown timer with pause, saturating bonus pickups and BCD output.
// State decodes are registered from next state; time_bcd trails time_left by one cycle.
module level_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ     = 65_000_000,
    parameter int LEVEL_TIME = LEVEL_TIME_DEF,
    parameter int BONUS_TIME = BONUS_TIME_DEF,
    parameter int MAX_TIME   = MAX_TIME_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       next_level,
    input  logic       pause,
    input  logic       add_time,
    output logic [6:0] time_left,
    output logic [7:0] time_bcd,
    output logic       time_up,
    output logic       running
);

    timer_state_t r_state;
    timer_state_t w_state_nxt;

    logic [6:0] r_time_left;
    logic [6:0] w_time_nxt;
    logic [7:0] r_time_bcd;
    logic       r_time_up;
    logic       r_running;
    logic       r_add_d;

    logic       w_tick;
    logic       w_bonus;
    logic       w_presc_en;
    logic       w_presc_clr;
    logic [8:0] w_dec;
    logic [8:0] w_sum;
    logic [6:0] w_sat;
    logic [7:0] w_tl8;
    logic [3:0] w_tens;
    logic [3:0] w_ones;

    assign w_presc_en  = (r_state == ST_RUN) & ~pause;
    assign w_presc_clr = (r_state == ST_LOAD);

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_presc_en),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

    // Bonus edges are honoured while paused but only in RUN.
    assign w_bonus = add_time & ~r_add_d & (r_state == ST_RUN);

    // Nine-bit intermediates keep tick/bonus arithmetic free of wrap.
    assign w_dec = w_tick  ? {2'b00, r_time_left} - 9'd1 : {2'b00, r_time_left};
    assign w_sum = w_bonus ? w_dec + 9'(BONUS_TIME)       : w_dec;
    assign w_sat = (w_sum > 9'(MAX_TIME)) ? 7'(MAX_TIME) : w_sum[6:0];

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time_left;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_time_nxt  = 7'(LEVEL_TIME);
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start | next_level) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_time_nxt = w_sat;
                    if (w_sat == 7'd0) begin
                        w_state_nxt = ST_TIMEOUT;
                    end
                end
            end
            ST_TIMEOUT: begin
                w_time_nxt = 7'd0;
                if (start | next_level) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_tl8  = {1'b0, r_time_left};
    assign w_tens = 4'(w_tl8 / 8'd10);
    assign w_ones = 4'(w_tl8 % 8'd10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_time_left <= 7'd0;
            r_time_bcd  <= 8'h00;
            r_time_up   <= 1'b0;
            r_running   <= 1'b0;
            r_add_d     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time_left <= w_time_nxt;
            r_time_bcd  <= {w_tens, w_ones};
            r_time_up   <= (w_state_nxt == ST_TIMEOUT);
            r_running   <= (w_state_nxt == ST_RUN);
            r_add_d     <= add_time;
        end
    end

    assign time_left = r_time_left;
    assign time_bcd  = r_time_bcd;
    assign time_up   = r_time_up;
    assign running   = r_running;

endmodule

// File: tb/tb_level_timer.sv
// Bench for level_timer: per-cycle comparison against an arithmetic game-timer model
// plus directed scenarios with hand-computed values.
module tb_level_timer;

    localparam int CLK_HZ = 10;
    localparam int LEVEL  = 60;
    localparam int BONUS  = 10;
    localparam int MAXT   = 99;

    logic       clk;
    logic       rst;
    logic       start;
    logic       next_level;
    logic       pause;
    logic       add_time;
    logic [6:0] time_left;
    logic [7:0] time_bcd;
    logic       time_up;
    logic       running;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    level_timer #(
        .CLK_HZ     (CLK_HZ),
        .LEVEL_TIME (LEVEL),
        .BONUS_TIME (BONUS),
        .MAX_TIME   (MAXT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .next_level (next_level),
        .pause      (pause),
        .add_time   (add_time),
        .time_left  (time_left),
        .time_bcd   (time_bcd),
        .time_up    (time_up),
        .running    (running)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Game model: phase 0=idle 1=load 2=run 3=timeout, seconds and sub-second count as ints.
    int m_phase = 0;
    int m_secs  = 0;
    int m_sub   = 0;
    int m_bcd   = 0;
    bit m_prev  = 0;

    always @(posedge clk) begin
        bit got_bonus;
        bit got_tick;
        int nt;
        if (rst) begin
            m_phase = 0; m_secs = 0; m_sub = 0; m_bcd = 0; m_prev = 0;
        end else begin
            got_bonus = add_time && !m_prev && (m_phase == 2);
            got_tick  = (m_phase == 2) && !pause && (m_sub == CLK_HZ - 1);
            m_bcd = (m_secs / 10) * 16 + (m_secs % 10);
            case (m_phase)
                0: if (start) m_phase = 1;
                1: begin m_secs = LEVEL; m_sub = 0; m_phase = 2; end
                2: begin
                    if (!pause) m_sub = (m_sub + 1) % CLK_HZ;
                    if (start || next_level) m_phase = 1;
                    else begin
                        nt = m_secs - (got_tick ? 1 : 0) + (got_bonus ? BONUS : 0);
                        if (nt > MAXT) nt = MAXT;
                        m_secs = nt;
                        if (nt == 0) m_phase = 3;
                    end
                end
                default: begin m_secs = 0; if (start || next_level) m_phase = 1; end
            endcase
            m_prev = add_time;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model time_left", time_left, m_secs);
            chk("model time_bcd", time_bcd, m_bcd);
            chk("model time_up", time_up, m_phase == 3);
            chk("model running", running, m_phase == 2);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bonus_pulse();
        add_time = 1; step(1);
        add_time = 0; step(1);
    endtask

    initial begin
        rst = 1; start = 0; next_level = 0; pause = 0; add_time = 0;
        step(1);
        chk_en = 1;
        step(2);
        chk("rst time_left", time_left, 0);
        chk("rst time_bcd", time_bcd, 0);
        chk("rst time_up", time_up, 0);
        chk("rst running", running, 0);

        // Release with add_time high, then poke next_level and add_time in IDLE.
        add_time = 1; rst = 0; step(2);
        add_time = 0; next_level = 1; step(1);
        next_level = 0; step(1);
        bonus_pulse();
        chk("idle ignores time_left", time_left, 0);
        chk("idle ignores running", running, 0);

        // Start and count down to timeout.
        start = 1; step(1); start = 0;
        chk("load running", running, 0);
        step(1);
        chk("run load value", time_left, 60);
        chk("run running", running, 1);
        chk("run bcd lag", time_bcd, 8'h00);
        step(9);
        chk("before first tick", time_left, 60);
        step(1);
        chk("first tick", time_left, 59);
        chk("first tick bcd lag", time_bcd, 8'h60);
        step(1);
        chk("bcd 59", time_bcd, 8'h59);
        step(588);
        chk("last second", time_left, 1);
        step(1);
        chk("timeout time_left", time_left, 0);
        chk("timeout time_up", time_up, 1);
        chk("timeout running", running, 0);
        step(5);
        chk("timeout hold", time_up, 1);

        // next_level out of TIMEOUT.
        next_level = 1; step(1); next_level = 0;
        chk("reload load time_up", time_up, 0);
        chk("reload load running", running, 0);
        step(1);
        chk("reload time_left", time_left, 60);
        chk("reload running", running, 1);
        step(1);
        chk("reload bcd", time_bcd, 8'h60);

        // Long add_time level gives a single bonus.
        step(349);
        chk("at 25", time_left, 25);
        add_time = 1; step(1);
        chk("bonus 35", time_left, 35);
        step(49);
        chk("held level one bonus", time_left, 30);
        add_time = 0; step(1);
        chk("after release", time_left, 30);

        // Pause mid-count, resume with the remaining prescaler count.
        step(4);
        pause = 1; step(100);
        chk("paused constant", time_left, 30);
        pause = 0; step(4);
        chk("resume before tick", time_left, 30);
        step(1);
        chk("resume tick", time_left, 29);

        // Saturation, with bonuses applied while paused.
        step(40);
        chk("at 25 again", time_left, 25);
        pause = 1;
        repeat (7) bonus_pulse();
        chk("reach 95", time_left, 95);
        bonus_pulse();
        chk("95 saturates to 99", time_left, 99);
        bonus_pulse();
        chk("99 stays 99", time_left, 99);
        pause = 0;

        // Bonus coincident with the tick at 1 second.
        step(989);
        chk("down to 1", time_left, 1);
        add_time = 1; step(1); add_time = 0;
        chk("tick+bonus at 1", time_left, 10);
        chk("tick+bonus running", running, 1);
        chk("tick+bonus time_up", time_up, 0);

        // Reset mid-run, then start+next_level together with add_time held.
        step(5);
        rst = 1; step(1);
        chk("midrun rst time_left", time_left, 0);
        chk("midrun rst bcd", time_bcd, 0);
        chk("midrun rst running", running, 0);
        chk("midrun rst time_up", time_up, 0);
        rst = 0;
        bonus_pulse();
        chk("idle bonus ignored", time_left, 0);
        start = 1; next_level = 1; add_time = 1; step(1);
        start = 0; next_level = 0; step(1);
        chk("start+next_level load", time_left, 60);
        chk("start+next_level running", running, 1);
        step(3);
        chk("held add_time no bonus", time_left, 60);
        add_time = 0; step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
